// File: rtl/pgs_tsmac_gmii_tx_arbiter_v1_0.sv
// Two-source round-robin GMII transmit scheduler with minimum inter-frame gap and underrun abort.
// Optional frame-length watchdog enabled by defining PGS_TSMAC_TX_ARB_WDOG_EN.
module pgs_tsmac_gmii_tx_arbiter_v1_0 #(
   parameter int IFG_CYCLES = 12,
   parameter int MAX_FRAME  = 1530
) (
   input  logic        tx_clk,
   input  logic        tx_rst,
   input  logic [1:0]  src_req,
   output logic [1:0]  src_gnt,
   input  logic [15:0] src_data,
   input  logic [1:0]  src_vld,
   input  logic [1:0]  src_last,
   input  logic [1:0]  src_er,
   output logic        tx_en_gm,
   output logic [7:0]  txd_gm,
   output logic        tx_er_gm,
   output logic        arb_abort
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_IFG  = 2'd2;

   localparam int IFG_LOAD = IFG_CYCLES - 1;

   logic [1:0] state;
   logic       sel;
   logic       last_ptr;
   logic       started;
   logic [7:0] ifg_cnt;

   logic       cur_vld;
   logic       cur_last;
   logic       cur_req;
   logic       cur_er;
   logic [7:0] cur_data;
   logic       next_sel;
   logic       wdog_hit;

   assign cur_vld  = sel ? src_vld[1]      : src_vld[0];
   assign cur_last = sel ? src_last[1]     : src_last[0];
   assign cur_req  = sel ? src_req[1]      : src_req[0];
   assign cur_er   = sel ? src_er[1]       : src_er[0];
   assign cur_data = sel ? src_data[15:8]  : src_data[7:0];

   // On a tie the source not served last wins; otherwise the lone requester.
   assign next_sel = (src_req == 2'b11) ? ~last_ptr : src_req[1];

   assign src_gnt = (state == ST_SEND) ? {sel, ~sel} : 2'b00;

`ifdef PGS_TSMAC_TX_ARB_WDOG_EN
   logic [10:0] byte_cnt;

   assign wdog_hit = (byte_cnt == 11'(MAX_FRAME - 1));

   // Counter idles at zero outside SEND, so every frame starts counting from zero.
   always_ff @(posedge tx_clk) begin
      if (tx_rst) begin
         byte_cnt <= '0;
      end else if (state != ST_SEND) begin
         byte_cnt <= '0;
      end else if (cur_vld) begin
         byte_cnt <= byte_cnt + 11'd1;
      end
   end
`else
   localparam int unused_max_frame = MAX_FRAME;

   assign wdog_hit = 1'b0;
`endif

   always_ff @(posedge tx_clk) begin
      if (tx_rst) begin
         state     <= ST_IDLE;
         sel       <= 1'b0;
         last_ptr  <= 1'b1;
         started   <= 1'b0;
         ifg_cnt   <= '0;
         tx_en_gm  <= 1'b0;
         txd_gm    <= '0;
         tx_er_gm  <= 1'b0;
         arb_abort <= 1'b0;
      end else begin
         tx_en_gm  <= 1'b0;
         txd_gm    <= '0;
         tx_er_gm  <= 1'b0;
         arb_abort <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (|src_req) begin
                  sel     <= next_sel;
                  started <= 1'b0;
                  state   <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (cur_vld) begin
                  tx_en_gm <= 1'b1;
                  txd_gm   <= cur_data;
                  started  <= 1'b1;
                  if (cur_last) begin
                     tx_er_gm <= cur_er;
                     last_ptr <= sel;
                     ifg_cnt  <= 8'(IFG_LOAD);
                     state    <= ST_IFG;
                  end else if (wdog_hit) begin
                     tx_er_gm  <= 1'b1;
                     arb_abort <= 1'b1;
                     last_ptr  <= sel;
                     ifg_cnt   <= 8'(IFG_LOAD);
                     state     <= ST_IFG;
                  end else begin
                     tx_er_gm <= cur_er;
                  end
               end else if (started) begin
                  // Underrun mid-frame: emit one poisoned byte so the frame is rejected downstream.
                  tx_en_gm  <= 1'b1;
                  tx_er_gm  <= 1'b1;
                  arb_abort <= 1'b1;
                  last_ptr  <= sel;
                  ifg_cnt   <= 8'(IFG_LOAD);
                  state     <= ST_IFG;
               end else if (!cur_req) begin
                  state <= ST_IDLE;
               end
            end
            ST_IFG: begin
               if (ifg_cnt == 8'd0) begin
                  if (|src_req) begin
                     sel     <= next_sel;
                     started <= 1'b0;
                     state   <= ST_SEND;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  ifg_cnt <= ifg_cnt - 8'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/pgs_tsmac_gmii_tx_arbiter_v1_0.md
# pgs_tsmac_gmii_tx_arbiter_v1_0

Two-source GMII transmit scheduler sitting in front of the GMII-to-RGMII converter on the `tx_clk` domain. It grants the single GMII transmit port to one of two frame sources by round-robin and forwards the granted byte stream as `tx_en_gm`/`txd_gm`/`tx_er_gm`. It enforces a programmable minimum inter-frame gap and aborts frames on source underrun, flagging the abort with `tx_er_gm`.

## Interface
Parameters:
- `IFG_CYCLES`, 12: minimum idle `tx_clk` cycles between frames on the GMII output; legal range 1..255.
- `MAX_FRAME`, 1530: byte limit per frame; used only with the watchdog macro; legal range 2..2047.

Ports:
- `tx_clk`  in  1  GMII transmit clock; the single clock.
- `tx_rst`  in  1  synchronous, active-high reset.
- `src_req`  in  2  per-source frame request; bit i belongs to source i.
- `src_gnt`  out  2  per-source grant, one-hot or zero.
- `src_data`  in  16  byte for source i in `[8i+7:8i]`.
- `src_vld`  in  2  byte valid.
- `src_last`  in  2  final byte of frame, qualified by `src_vld`.
- `src_er`  in  2  per-byte error from source, passed to `tx_er_gm`.
- `tx_en_gm`  out  1  GMII transmit enable, to converter.
- `txd_gm`  out  8  GMII transmit data, to converter.
- `tx_er_gm`  out  1  GMII transmit error, to converter.
- `arb_abort`  out  1  one-cycle pulse when a frame is aborted.

## Operation
- States: IDLE, SEND, IFG.
- **IDLE:** if any `src_req` is high, select a source and go to SEND next cycle.
  - Only one requesting: select it.
  - Both requesting: select the source not served last.
  - Last-served pointer resets to 1, so source 0 wins the first tie.
- **SEND:** `src_gnt[sel]` is high for the whole state, driven as a decode of state and `sel`. A byte is accepted in any cycle where `src_gnt[sel] & src_vld[sel]`.
  - Before the first byte (frame not started):
    - `src_vld` low: wait, no timeout.
    - `src_req[sel]` drops: return to IDLE; no IFG, pointer unchanged.
  - After the first byte (started):
    - `src_req` is ignored.
    - Accepted byte with `src_last`: go to IFG and update the pointer to `sel`.
    - `src_vld[sel]` low: underrun. Output one byte `txd_gm`=0x00 with `tx_en_gm`=1, `tx_er_gm`=1; pulse `arb_abort`; go to IFG; update the pointer.
- **IFG:** counter loads `IFG_CYCLES`-1 on entry and decrements to 0. In the cycle with count 0:
  - any request pending: arbitrate and go directly to SEND;
  - otherwise go to IDLE.
- **Outputs:** registered. An accepted byte drives `txd_gm`/`tx_er_gm`=`src_er[sel]`/`tx_en_gm`=1 in the following cycle. In cycles with no accepted byte and no underrun, all three are 0.
- **Reset mid-frame:** next cycle all outputs 0 and the state is IDLE. A truncated frame on the wire is acceptable; no `tx_er` is emitted.

## Timing
- Reset values: `src_gnt`=0, `tx_en_gm`=0, `txd_gm`=0x00, `tx_er_gm`=0, `arb_abort`=0, state IDLE, IFG counter 0.
- Request-to-grant: `src_req` high in IDLE at cycle T gives `src_gnt` high at T+1.
- Data latency: byte accepted at T appears on `txd_gm` at T+1.
- Grant release: last byte accepted at N drops `src_gnt` at N+1.
- Back-to-back frames: with `src_vld` held high, `tx_en_gm` is low for exactly `IFG_CYCLES` cycles (N+2 .. N+IFG_CYCLES+1) between frames; never fewer.
- Source contract: after the first byte, a source must hold `src_vld` high every cycle until `src_last`.

## Configuration
- Macro: `PGS_TSMAC_TX_ARB_WDOG_EN`.
- **Defined:**
  - An 11-bit accepted-byte counter per frame is built, cleared on entry to SEND.
  - If byte number `MAX_FRAME` is accepted without `src_last`, it is output with `tx_er_gm`=1, `arb_abort` pulses, and the state goes to IFG (grant dropped, pointer updated).
  - The source must discard the rest of its frame when `src_gnt` falls.
- **Undefined:** no counter logic; frame length is unbounded; `arb_abort` signals underrun only.

## Test plan
- Single frame: source 0 sends 64 bytes 0x00..0x3F with `IFG_CYCLES`=12 -> `tx_en_gm` high for 64 consecutive cycles starting 1 cycle after the first accept; data matches; `tx_er_gm`=0; `src_gnt` = 2'b01 then 0.
- Contention: both sources request continuously, 60-byte frames each -> frames alternate 0,1,0,1; source 0 goes first; exactly 12 idle cycles between frames.
- Underrun: source 1 drops `src_vld` after byte 10 -> output bytes 1..10 followed by one 0x00 byte with `tx_er_gm`=1; `arb_abort` pulses once; next grant comes 12 idle cycles later.
- Request withdrawal: source 0 raises and drops `src_req` before any `src_vld` -> no `tx_en_gm`, no IFG; source 1 granted on its next request within 2 cycles.
- Watchdog (macro defined, `MAX_FRAME`=100): 150-byte frame -> byte 100 carries `tx_er_gm`=1; `tx_en_gm` falls after byte 100; `arb_abort` pulses.
- Reset: assert `tx_rst` mid-frame -> next cycle all outputs 0; after release, a new request is granted 1 cycle later.
